// File: rtl/video_mode_mon_pkg.sv
// Shared types and constants for the ISL51002 input-mode monitor.
// The pixel-count tolerance match is enabled by VIDEO_MODE_MON_PCNT_CHECK_EN.
package video_mode_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_NOSYNC  = 2'd1,
    ST_ACQUIRE = 2'd2,
    ST_STABLE  = 2'd3
  } mon_state_t;

  localparam int VTOTAL_W     = 11;
  localparam int PCNT_W       = 20;
  localparam int SAMPLE_DELAY = 4;
  localparam int DELAY_W      = 3;
  localparam int MATCH_W      = 4;

  // Both counts are widened by one bit so the difference cannot wrap.
  function automatic logic pcnt_in_tol(input logic [PCNT_W-1:0] meas,
                                       input logic [PCNT_W-1:0] ref_val,
                                       input int                tol);
    logic signed [PCNT_W:0] diff;
    logic signed [PCNT_W:0] mag;
    diff = $signed({1'b0, meas}) - $signed({1'b0, ref_val});
    mag  = (diff < 0) ? -diff : diff;
    return (mag <= (PCNT_W+1)'(tol));
  endfunction

endpackage

// File: rtl/video_mode_monitor_frame_edge_sampler.sv
// VSYNC rising-edge detector plus the delayed sample strobe that tells the
// monitor when the frontend frame measurements have settled.
module frame_edge_sampler
  import video_mode_mon_pkg::*;
(
  input  logic clk27,
  input  logic reset_n,
  input  logic i_enable,
  input  logic i_vsync,
  output logic o_edge,
  output logic o_strobe
);

  logic               r_vsPrev;
  logic               r_pending;
  logic [DELAY_W-1:0] r_delayCnt;
  logic               r_strobe;
  logic               w_edge;

  assign w_edge = i_vsync & ~r_vsPrev;

  // A fresh edge while a sample is pending restarts the delay from one.
  always_ff @(posedge clk27) begin
    if (!reset_n) begin
      r_vsPrev   <= 1'b0;
      r_pending  <= 1'b0;
      r_delayCnt <= '0;
      r_strobe   <= 1'b0;
    end else begin
      r_vsPrev <= i_vsync;
      r_strobe <= 1'b0;
      if (!i_enable) begin
        r_pending  <= 1'b0;
        r_delayCnt <= '0;
      end else if (w_edge) begin
        r_pending  <= 1'b1;
        r_delayCnt <= DELAY_W'(1);
      end else if (r_pending) begin
        if (r_delayCnt == DELAY_W'(SAMPLE_DELAY - 1)) begin
          r_strobe   <= 1'b1;
          r_pending  <= 1'b0;
          r_delayCnt <= '0;
        end else begin
          r_delayCnt <= r_delayCnt + DELAY_W'(1);
        end
      end
    end
  end

  assign o_edge   = w_edge;
  assign o_strobe = r_strobe;

endmodule

// File: rtl/video_mode_monitor.sv
// Input-mode supervisor: locks onto a stable frame format, mutes output while
// unlocked and raises a sticky IRQ on lock/unlock. Macro: VIDEO_MODE_MON_PCNT_CHECK_EN.
module video_mode_monitor
  import video_mode_mon_pkg::*;
#(
  parameter int TIMEOUT_CYC   = 2700000,
  parameter int STABLE_FRAMES = 3,
  parameter int PCNT_TOL      = 4
) (
  input  logic                clk27,
  input  logic                reset_n,
  input  logic                enable_i,
  input  logic                vsync_i,
  input  logic [VTOTAL_W-1:0] vtotal_i,
  input  logic                interlace_i,
  input  logic [PCNT_W-1:0]   pcnt_frame_i,
  input  logic                irq_ack_i,
  output logic                sync_active_o,
  output logic                mode_stable_o,
  output logic                output_mute_o,
  output logic                irq_o,
  output logic [7:0]          change_cnt_o,
  output logic [VTOTAL_W-1:0] ref_vtotal_o,
  output logic                ref_interlace_o,
  output logic [PCNT_W-1:0]   ref_pcnt_o
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

`ifdef VIDEO_MODE_MON_PCNT_CHECK_EN
  localparam bit PCNT_CHECK = 1'b1;
`else
  localparam bit PCNT_CHECK = 1'b0;
`endif

  mon_state_t          r_state;
  logic [MATCH_W-1:0]  r_matchCnt;
  logic [TO_W-1:0]     r_toCnt;
  logic [VTOTAL_W-1:0] r_refVtotal;
  logic                r_refInterlace;
  logic [PCNT_W-1:0]   r_refPcnt;
  logic                r_irq;
  logic [7:0]          r_changeCnt;
  logic                r_mute;
  logic                r_modeStable;
  logic                r_syncActive;

  logic                w_edge;
  logic                w_strobe;
  logic                w_timeout;
  logic                w_pcntOk;
  logic                w_match;
  logic [MATCH_W-1:0]  w_matchNext;

  frame_edge_sampler u_sampler (
    .clk27    (clk27),
    .reset_n  (reset_n),
    .i_enable (enable_i),
    .i_vsync  (vsync_i),
    .o_edge   (w_edge),
    .o_strobe (w_strobe)
  );

  assign w_pcntOk    = !PCNT_CHECK || pcnt_in_tol(pcnt_frame_i, r_refPcnt, PCNT_TOL);
  assign w_match     = (vtotal_i == r_refVtotal) && (interlace_i == r_refInterlace) && w_pcntOk;
  assign w_matchNext = r_matchCnt + MATCH_W'(1);
  assign w_timeout   = (r_toCnt == TO_W'(TIMEOUT_CYC - 1));

  // Cycles since the last frame edge, holding once the timeout is reached.
  always_ff @(posedge clk27) begin
    if (!reset_n) begin
      r_toCnt <= '0;
    end else if (!enable_i || w_edge) begin
      r_toCnt <= '0;
    end else if (!w_timeout) begin
      r_toCnt <= r_toCnt + TO_W'(1);
    end
  end

  // Timeout is checked before the strobe in every state so it takes priority.
  // The IRQ clear sits first so a same-cycle lock/unlock set overrides it.
  always_ff @(posedge clk27) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_matchCnt     <= '0;
      r_refVtotal    <= '0;
      r_refInterlace <= 1'b0;
      r_refPcnt      <= '0;
      r_irq          <= 1'b0;
      r_changeCnt    <= '0;
      r_mute         <= 1'b1;
      r_modeStable   <= 1'b0;
      r_syncActive   <= 1'b0;
    end else begin
      r_syncActive <= enable_i & ~w_timeout;
      if (irq_ack_i) begin
        r_irq <= 1'b0;
      end
      if (!enable_i) begin
        r_state      <= ST_IDLE;
        r_matchCnt   <= '0;
        r_mute       <= 1'b1;
        r_modeStable <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_NOSYNC;
          end
          ST_NOSYNC: begin
            if (!w_timeout && w_strobe) begin
              r_refVtotal    <= vtotal_i;
              r_refInterlace <= interlace_i;
              r_refPcnt      <= pcnt_frame_i;
              r_matchCnt     <= '0;
              r_state        <= ST_ACQUIRE;
            end
          end
          ST_ACQUIRE: begin
            if (w_timeout) begin
              r_state <= ST_NOSYNC;
            end else if (w_strobe) begin
              if (w_match) begin
                r_matchCnt <= w_matchNext;
                if (w_matchNext == MATCH_W'(STABLE_FRAMES)) begin
                  r_state      <= ST_STABLE;
                  r_mute       <= 1'b0;
                  r_modeStable <= 1'b1;
                  r_irq        <= 1'b1;
                  r_changeCnt  <= r_changeCnt + 8'd1;
                end
              end else begin
                r_refVtotal    <= vtotal_i;
                r_refInterlace <= interlace_i;
                r_refPcnt      <= pcnt_frame_i;
                r_matchCnt     <= '0;
              end
            end
          end
          ST_STABLE: begin
            if (w_timeout) begin
              r_state      <= ST_NOSYNC;
              r_mute       <= 1'b1;
              r_modeStable <= 1'b0;
              r_irq        <= 1'b1;
              r_changeCnt  <= r_changeCnt + 8'd1;
            end else if (w_strobe && !w_match) begin
              r_refVtotal    <= vtotal_i;
              r_refInterlace <= interlace_i;
              r_refPcnt      <= pcnt_frame_i;
              r_matchCnt     <= '0;
              r_state        <= ST_ACQUIRE;
              r_mute         <= 1'b1;
              r_modeStable   <= 1'b0;
              r_irq          <= 1'b1;
              r_changeCnt    <= r_changeCnt + 8'd1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign sync_active_o   = r_syncActive;
  assign mode_stable_o   = r_modeStable;
  assign output_mute_o   = r_mute;
  assign irq_o           = r_irq;
  assign change_cnt_o    = r_changeCnt;
  assign ref_vtotal_o    = r_refVtotal;
  assign ref_interlace_o = r_refInterlace;
  assign ref_pcnt_o      = r_refPcnt;

endmodule

// File: tb/tb_video_mode_monitor.sv
// Directed self-checking bench for video_mode_monitor with a shortened timeout
// and frame period; expectations follow VIDEO_MODE_MON_PCNT_CHECK_EN when set.
module tb_video_mode_monitor;

  localparam int T_CYC  = 300;
  localparam int SF     = 3;
  localparam int TOL    = 4;
  localparam int PERIOD = 100;
  localparam logic [19:0] PC0 = 20'd450450;

  logic        clk27;
  logic        reset_n;
  logic        enable_i;
  logic        vsync_i;
  logic [10:0] vtotal_i;
  logic        interlace_i;
  logic [19:0] pcnt_frame_i;
  logic        irq_ack_i;
  logic        sync_active_o;
  logic        mode_stable_o;
  logic        output_mute_o;
  logic        irq_o;
  logic [7:0]  change_cnt_o;
  logic [10:0] ref_vtotal_o;
  logic        ref_interlace_o;
  logic [19:0] ref_pcnt_o;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  expChg;
  logic [19:0] refP;

  video_mode_monitor #(
    .TIMEOUT_CYC   (T_CYC),
    .STABLE_FRAMES (SF),
    .PCNT_TOL      (TOL)
  ) dut (
    .clk27           (clk27),
    .reset_n         (reset_n),
    .enable_i        (enable_i),
    .vsync_i         (vsync_i),
    .vtotal_i        (vtotal_i),
    .interlace_i     (interlace_i),
    .pcnt_frame_i    (pcnt_frame_i),
    .irq_ack_i       (irq_ack_i),
    .sync_active_o   (sync_active_o),
    .mode_stable_o   (mode_stable_o),
    .output_mute_o   (output_mute_o),
    .irq_o           (irq_o),
    .change_cnt_o    (change_cnt_o),
    .ref_vtotal_o    (ref_vtotal_o),
    .ref_interlace_o (ref_interlace_o),
    .ref_pcnt_o      (ref_pcnt_o)
  );

  initial clk27 = 1'b0;
  always #5 clk27 = ~clk27;

  task automatic tick();
    @(posedge clk27);
    #1;
  endtask

  // One frame: VSYNC high for two cycles; stability sampled just before and
  // just after the fifth clock, where a state change lands.
  task automatic runFrame(input logic [10:0] vt, input logic il, input logic [19:0] pc,
                          input bit ackAtLock, output logic preStable, output logic postStable);
    vtotal_i     = vt;
    interlace_i  = il;
    pcnt_frame_i = pc;
    vsync_i      = 1'b1;
    tick();
    tick();
    vsync_i = 1'b0;
    tick();
    tick();
    preStable = mode_stable_o;
    if (ackAtLock) irq_ack_i = 1'b1;
    tick();
    irq_ack_i  = 1'b0;
    postStable = mode_stable_o;
    repeat (PERIOD - 5) tick();
  endtask

  task automatic ackIrq();
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_ack_clear: got %0b expected 0", irq_o); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable_i = 1'b0; vsync_i = 1'b0; irq_ack_i = 1'b0;
    vtotal_i = '0; interlace_i = 1'b0; pcnt_frame_i = '0;
    repeat (3) tick();
    checks++; if (output_mute_o !== 1'b1) begin errors++; $display("FAIL reset_mute: got %0b expected 1", output_mute_o); end
    checks++; if (mode_stable_o !== 1'b0) begin errors++; $display("FAIL reset_stable: got %0b expected 0", mode_stable_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b expected 0", irq_o); end
    checks++; if (sync_active_o !== 1'b0) begin errors++; $display("FAIL reset_sync: got %0b expected 0", sync_active_o); end
    checks++; if (change_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_chg: got %0d expected 0", change_cnt_o); end
    checks++; if (ref_vtotal_o !== 11'd0) begin errors++; $display("FAIL reset_refvt: got %0d expected 0", ref_vtotal_o); end
    reset_n  = 1'b1;
    enable_i = 1'b1;
    tick();
  endtask

  // Second edge two cycles after the first must push the sample back.
  task automatic test_delay_restart();
    vtotal_i = 11'd720; interlace_i = 1'b1; pcnt_frame_i = 20'd12345;
    vsync_i = 1'b1; tick();
    vsync_i = 1'b0; tick();
    vsync_i = 1'b1; tick();
    vsync_i = 1'b0; tick();
    tick();
    checks++; if (ref_vtotal_o !== 11'd0) begin errors++; $display("FAIL restart_early: got %0d expected 0", ref_vtotal_o); end
    tick();
    tick();
    checks++; if (ref_vtotal_o !== 11'd720) begin errors++; $display("FAIL restart_load_vt: got %0d expected 720", ref_vtotal_o); end
    checks++; if (ref_interlace_o !== 1'b1) begin errors++; $display("FAIL restart_load_il: got %0b expected 1", ref_interlace_o); end
    checks++; if (output_mute_o !== 1'b1) begin errors++; $display("FAIL restart_mute: got %0b expected 1", output_mute_o); end
    repeat (PERIOD - 7) tick();
  endtask

  task automatic test_lock();
    logic pre, post;
    runFrame(11'd525, 1'b0, PC0, 1'b0, pre, post);
    checks++; if (ref_vtotal_o !== 11'd525) begin errors++; $display("FAIL lock_refvt: got %0d expected 525", ref_vtotal_o); end
    checks++; if (ref_interlace_o !== 1'b0) begin errors++; $display("FAIL lock_refil: got %0b expected 0", ref_interlace_o); end
    checks++; if (ref_pcnt_o !== PC0) begin errors++; $display("FAIL lock_refpc: got %0d expected %0d", ref_pcnt_o, PC0); end
    runFrame(11'd525, 1'b0, PC0, 1'b0, pre, post);
    runFrame(11'd525, 1'b0, PC0, 1'b0, pre, post);
    checks++; if (mode_stable_o !== 1'b0) begin errors++; $display("FAIL lock_early: got %0b expected 0", mode_stable_o); end
    runFrame(11'd525, 1'b0, PC0, 1'b0, pre, post);
    checks++; if (pre !== 1'b0) begin errors++; $display("FAIL lock_latency4: got %0b expected 0", pre); end
    checks++; if (post !== 1'b1) begin errors++; $display("FAIL lock_latency5: got %0b expected 1", post); end
    checks++; if (output_mute_o !== 1'b0) begin errors++; $display("FAIL lock_mute: got %0b expected 0", output_mute_o); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL lock_irq: got %0b expected 1", irq_o); end
    expChg = 8'd1;
    checks++; if (change_cnt_o !== expChg) begin errors++; $display("FAIL lock_chg: got %0d expected %0d", change_cnt_o, expChg); end
    ackIrq();
  endtask

  task automatic test_tolerance();
    logic pre, post;
    logic expStable;
    logic [19:0] expRef;
    runFrame(11'd525, 1'b0, PC0 + 20'd4, 1'b0, pre, post);
    runFrame(11'd525, 1'b0, PC0 - 20'd4, 1'b0, pre, post);
    runFrame(11'd525, 1'b0, PC0 + 20'd4, 1'b0, pre, post);
    checks++; if (mode_stable_o !== 1'b1) begin errors++; $display("FAIL tol_within_stable: got %0b expected 1", mode_stable_o); end
    checks++; if (change_cnt_o !== expChg) begin errors++; $display("FAIL tol_within_chg: got %0d expected %0d", change_cnt_o, expChg); end
    runFrame(11'd525, 1'b0, PC0 + 20'd5, 1'b0, pre, post);
`ifdef VIDEO_MODE_MON_PCNT_CHECK_EN
    expStable = 1'b0;
    expChg    = expChg + 8'd1;
`else
    expStable = 1'b1;
`endif
    expRef = expStable ? PC0 : PC0 + 20'd5;
    checks++; if (mode_stable_o !== expStable) begin errors++; $display("FAIL tol_over_stable: got %0b expected %0b", mode_stable_o, expStable); end
    checks++; if (output_mute_o !== ~expStable) begin errors++; $display("FAIL tol_over_mute: got %0b expected %0b", output_mute_o, ~expStable); end
    checks++; if (irq_o !== ~expStable) begin errors++; $display("FAIL tol_over_irq: got %0b expected %0b", irq_o, ~expStable); end
    checks++; if (change_cnt_o !== expChg) begin errors++; $display("FAIL tol_over_chg: got %0d expected %0d", change_cnt_o, expChg); end
    checks++; if (ref_pcnt_o !== expRef) begin errors++; $display("FAIL tol_over_ref: got %0d expected %0d", ref_pcnt_o, expRef); end
    refP = expRef;
    if (!expStable) begin
      ackIrq();
      repeat (SF) runFrame(11'd525, 1'b0, refP, 1'b0, pre, post);
      expChg = expChg + 8'd1;
      checks++; if (mode_stable_o !== 1'b1) begin errors++; $display("FAIL tol_relock: got %0b expected 1", mode_stable_o); end
      ackIrq();
    end
  endtask

  task automatic test_mode_change();
    logic pre, post;
    runFrame(11'd625, 1'b0, refP, 1'b0, pre, post);
    expChg = expChg + 8'd1;
    checks++; if (mode_stable_o !== 1'b0) begin errors++; $display("FAIL mode_unlock: got %0b expected 0", mode_stable_o); end
    checks++; if (output_mute_o !== 1'b1) begin errors++; $display("FAIL mode_mute: got %0b expected 1", output_mute_o); end
    checks++; if (ref_vtotal_o !== 11'd625) begin errors++; $display("FAIL mode_refvt: got %0d expected 625", ref_vtotal_o); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL mode_irq: got %0b expected 1", irq_o); end
    checks++; if (change_cnt_o !== expChg) begin errors++; $display("FAIL mode_chg: got %0d expected %0d", change_cnt_o, expChg); end
    ackIrq();
    runFrame(11'd625, 1'b0, refP, 1'b0, pre, post);
    runFrame(11'd625, 1'b0, refP, 1'b0, pre, post);
    checks++; if (mode_stable_o !== 1'b0) begin errors++; $display("FAIL mode_early: got %0b expected 0", mode_stable_o); end
    runFrame(11'd625, 1'b0, refP, 1'b1, pre, post);
    expChg = expChg + 8'd1;
    checks++; if (post !== 1'b1) begin errors++; $display("FAIL mode_relock: got %0b expected 1", post); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_set_beats_ack: got %0b expected 1", irq_o); end
    checks++; if (change_cnt_o !== expChg) begin errors++; $display("FAIL mode_relock_chg: got %0d expected %0d", change_cnt_o, expChg); end
    ackIrq();
  endtask

  // The edge registers on the first clock after VSYNC rises; NOSYNC must
  // appear exactly T_CYC clocks after that.
  task automatic test_sync_loss();
    vsync_i = 1'b1; tick();
    tick();
    vsync_i = 1'b0;
    repeat (T_CYC - 2) tick();
    checks++; if (mode_stable_o !== 1'b1) begin errors++; $display("FAIL loss_early_stable: got %0b expected 1", mode_stable_o); end
    checks++; if (sync_active_o !== 1'b1) begin errors++; $display("FAIL loss_early_sync: got %0b expected 1", sync_active_o); end
    tick();
    expChg = expChg + 8'd1;
    checks++; if (mode_stable_o !== 1'b0) begin errors++; $display("FAIL loss_stable: got %0b expected 0", mode_stable_o); end
    checks++; if (output_mute_o !== 1'b1) begin errors++; $display("FAIL loss_mute: got %0b expected 1", output_mute_o); end
    checks++; if (sync_active_o !== 1'b0) begin errors++; $display("FAIL loss_sync: got %0b expected 0", sync_active_o); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL loss_irq: got %0b expected 1", irq_o); end
    checks++; if (change_cnt_o !== expChg) begin errors++; $display("FAIL loss_chg: got %0d expected %0d", change_cnt_o, expChg); end
    repeat (10) tick();
  endtask

  task automatic test_reset_midacq();
    logic pre, post;
    runFrame(11'd525, 1'b1, PC0, 1'b0, pre, post);
    checks++; if (ref_interlace_o !== 1'b1) begin errors++; $display("FAIL acq_load_il: got %0b expected 1", ref_interlace_o); end
    checks++; if (sync_active_o !== 1'b1) begin errors++; $display("FAIL acq_sync: got %0b expected 1", sync_active_o); end
    reset_n = 1'b0;
    tick();
    checks++; if (output_mute_o !== 1'b1) begin errors++; $display("FAIL rst2_mute: got %0b expected 1", output_mute_o); end
    checks++; if (mode_stable_o !== 1'b0) begin errors++; $display("FAIL rst2_stable: got %0b expected 0", mode_stable_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL rst2_irq: got %0b expected 0", irq_o); end
    checks++; if (sync_active_o !== 1'b0) begin errors++; $display("FAIL rst2_sync: got %0b expected 0", sync_active_o); end
    checks++; if (change_cnt_o !== 8'd0) begin errors++; $display("FAIL rst2_chg: got %0d expected 0", change_cnt_o); end
    checks++; if (ref_vtotal_o !== 11'd0) begin errors++; $display("FAIL rst2_refvt: got %0d expected 0", ref_vtotal_o); end
    checks++; if (ref_interlace_o !== 1'b0) begin errors++; $display("FAIL rst2_refil: got %0b expected 0", ref_interlace_o); end
    checks++; if (ref_pcnt_o !== 20'd0) begin errors++; $display("FAIL rst2_refpc: got %0d expected 0", ref_pcnt_o); end
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    expChg = 8'd0;
    refP   = PC0;
    test_reset();
    test_delay_restart();
    test_lock();
    test_tolerance();
    test_mode_change();
    test_sync_loss();
    test_reset_midacq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
